// File: rtl/tx_chain_dig_multi.sv
// Multi-channel TX digital-steal stage: moves the low k bits of every I/Q word to GPIO
// outputs, zeroes them on the analog path, and idles GPIO when the sample stream stalls.
module tx_chain_dig_multi #(
  parameter int NUM_CHAN = 2,
  parameter int WIDTH    = 16,
  parameter int DIG_MAX  = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [$clog2(DIG_MAX+1)-1:0]    dig_bits,
  input  logic                            strobe,
  input  logic [NUM_CHAN*WIDTH-1:0]       i_in,
  input  logic [NUM_CHAN*WIDTH-1:0]       q_in,
  output logic [NUM_CHAN*WIDTH-1:0]       i_out_ana,
  output logic [NUM_CHAN*WIDTH-1:0]       q_out_ana,
  output logic [NUM_CHAN*DIG_MAX-1:0]     i_out_dig,
  output logic [NUM_CHAN*DIG_MAX-1:0]     q_out_dig,
  output logic                            out_strobe,
  output logic                            stale
);

  localparam int K_W   = $clog2(DIG_MAX + 1);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO    = CNT_W'((TIMEOUT > 0) ? TIMEOUT : 0);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  function automatic int eff_k(input logic en, input logic [K_W-1:0] bits);
    int k;
    k = 0;
    if (en) k = (int'(bits) > DIG_MAX) ? DIG_MAX : int'(bits);
    return k;
  endfunction

  function automatic logic [WIDTH-1:0] ana_word(input logic [WIDTH-1:0] w, input int k);
    logic [WIDTH-1:0] r;
    for (int b = 0; b < WIDTH; b++) r[b] = (b >= k) ? w[b] : 1'b0;
    return r;
  endfunction

  function automatic logic [DIG_MAX-1:0] dig_word(input logic [WIDTH-1:0] w, input int k);
    logic [DIG_MAX-1:0] r;
    for (int b = 0; b < DIG_MAX; b++) r[b] = (b < k) ? w[b] : 1'b0;
    return r;
  endfunction

  logic [NUM_CHAN*WIDTH-1:0]   i_ana_d, i_ana_q, q_ana_d, q_ana_q;
  logic [NUM_CHAN*DIG_MAX-1:0] i_dig_d, i_dig_q, q_dig_d, q_dig_q;
  logic                        out_strobe_d, out_strobe_q;
  logic                        stale_d, stale_q;
  logic [CNT_W-1:0]            cnt_d, cnt_q;
  int                          k;

  always_comb begin
    k            = eff_k(enable, dig_bits);
    i_ana_d      = i_ana_q;
    q_ana_d      = q_ana_q;
    i_dig_d      = i_dig_q;
    q_dig_d      = q_dig_q;
    out_strobe_d = 1'b0;
    stale_d      = stale_q;
    cnt_d        = cnt_q;
    if (strobe) begin
      out_strobe_d = 1'b1;
      stale_d      = 1'b0;
      cnt_d        = '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
        i_ana_d[c*WIDTH +: WIDTH]     = ana_word(i_in[c*WIDTH +: WIDTH], k);
        q_ana_d[c*WIDTH +: WIDTH]     = ana_word(q_in[c*WIDTH +: WIDTH], k);
        i_dig_d[c*DIG_MAX +: DIG_MAX] = dig_word(i_in[c*WIDTH +: WIDTH], k);
        q_dig_d[c*DIG_MAX +: DIG_MAX] = dig_word(q_in[c*WIDTH +: WIDTH], k);
      end
    end else if (TIMEOUT > 0 && cnt_q != TMO) begin
      cnt_d = cnt_q + CNT_W'(1);
      // The edge on which the count reaches TIMEOUT is the one that idles GPIO.
      if (cnt_q == TMO_M1) begin
        stale_d = 1'b1;
        i_dig_d = '0;
        q_dig_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_ana_q      <= '0;
      q_ana_q      <= '0;
      i_dig_q      <= '0;
      q_dig_q      <= '0;
      out_strobe_q <= 1'b0;
      stale_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      i_ana_q      <= i_ana_d;
      q_ana_q      <= q_ana_d;
      i_dig_q      <= i_dig_d;
      q_dig_q      <= q_dig_d;
      out_strobe_q <= out_strobe_d;
      stale_q      <= stale_d;
      cnt_q        <= cnt_d;
    end
  end

  assign i_out_ana  = i_ana_q;
  assign q_out_ana  = q_ana_q;
  assign i_out_dig  = i_dig_q;
  assign q_out_dig  = q_dig_q;
  assign out_strobe = out_strobe_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_tx_chain_dig_multi.sv
// Scoreboard bench for tx_chain_dig_multi (2 channels, 16-bit words, DIG_MAX=4, TIMEOUT=8).
module tb_tx_chain_dig_multi;

  logic        clock = 1'b0;
  logic        reset, enable, strobe;
  logic [2:0]  dig_bits;
  logic [31:0] i_in, q_in, i_out_ana, q_out_ana;
  logic [7:0]  i_out_dig, q_out_dig;
  logic        out_strobe, stale;

  always #5 clock = ~clock;

  tx_chain_dig_multi #(.NUM_CHAN(2), .WIDTH(16), .DIG_MAX(4), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .dig_bits(dig_bits), .strobe(strobe),
    .i_in(i_in), .q_in(q_in), .i_out_ana(i_out_ana), .q_out_ana(q_out_ana),
    .i_out_dig(i_out_dig), .q_out_dig(q_out_dig), .out_strobe(out_strobe), .stale(stale)
  );

  typedef struct packed {
    logic [31:0] ia;
    logic [31:0] qa;
    logic [7:0]  id;
    logic [7:0]  qd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    strobe = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic en, input logic [2:0] db, input logic [31:0] i, input logic [31:0] q,
                      input logic [31:0] ia, input logic [31:0] qa, input logic [7:0] id, input logic [7:0] qd);
    exp_t e;
    enable = en; dig_bits = db; i_in = i; q_in = q; strobe = 1'b1;
    e.ia = ia; e.qa = qa; e.id = id; e.qd = qd;
    sb.push_back(e);
    step();
  endtask

  task automatic chk_outs(input string name, input logic [31:0] ia, input logic [31:0] qa,
                          input logic [7:0] id, input logic [7:0] qd, input logic st);
    chk({name, "_i_ana"}, i_out_ana, ia);
    chk({name, "_q_ana"}, q_out_ana, qa);
    chk({name, "_i_dig"}, i_out_dig, id);
    chk({name, "_q_dig"}, q_out_dig, qd);
    chk({name, "_stale"}, stale, st);
  endtask

  // Monitor: every presented sample must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (out_strobe === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_strobe: got 1 expected 0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_i_ana", i_out_ana, e.ia);
          chk("sb_q_ana", q_out_ana, e.qa);
          chk("sb_i_dig", i_out_dig, e.id);
          chk("sb_q_dig", q_out_dig, e.qd);
          chk("sb_stale", stale, 1'b0);
        end
      end
    end
  end

  initial begin
    logic [15:0] lo, hi;
    reset = 1'b1; strobe = 1'b1; enable = 1'b1; dig_bits = 3'd4;
    i_in = '0; q_in = '0;

    // Reset dominates strobe.
    repeat (3) begin
      i_in = $urandom; q_in = $urandom;
      step();
      chk_outs("reset", 32'h0, 32'h0, 8'h0, 8'h0, 1'b0);
      chk("reset_out_strobe", out_strobe, 1'b0);
    end
    reset = 1'b0;
    idle(1);

    // k = 1, 4 (clamped from 7), 2 back-to-back.
    send(1'b1, 3'd1, {16'h1111, 16'hABCD}, {16'h2222, 16'h0003},
         {16'h1110, 16'hABCC}, {16'h2222, 16'h0002}, 8'h11, 8'h01);
    chk("k1_out_strobe", out_strobe, 1'b1);
    send(1'b1, 3'd7, {16'h00FF, 16'h5A5A}, {16'h1237, 16'h8008},
         {16'h00F0, 16'h5A50}, {16'h1230, 16'h8000}, 8'hFA, 8'h78);
    send(1'b1, 3'd2, {16'hBEEF, 16'h0007}, {16'h0001, 16'hFFFE},
         {16'hBEEC, 16'h0004}, {16'h0000, 16'hFFFC}, 8'h33, 8'h12);

    // Disabled passthrough, then config churn between strobes must not disturb held outputs.
    send(1'b0, 3'd3, {16'h1234, 16'hFFFF}, {16'h0F0F, 16'hF0F1},
         {16'h1234, 16'hFFFF}, {16'h0F0F, 16'hF0F1}, 8'h00, 8'h00);
    strobe = 1'b0; enable = 1'b1; dig_bits = 3'd4;
    step();
    chk_outs("hold_a", {16'h1234, 16'hFFFF}, {16'h0F0F, 16'hF0F1}, 8'h00, 8'h00, 1'b0);
    chk("hold_a_out_strobe", out_strobe, 1'b0);
    enable = 1'b0; dig_bits = 3'd1;
    step();
    chk_outs("hold_b", {16'h1234, 16'hFFFF}, {16'h0F0F, 16'hF0F1}, 8'h00, 8'h00, 1'b0);
    send(1'b1, 3'd4, {16'h1234, 16'hFFFF}, {16'h0F0F, 16'hF0F1},
         {16'h1230, 16'hFFF0}, {16'h0F00, 16'hF0F0}, 8'h4F, 8'hF1);

    // Watchdog expiry exactly 8 idle edges after the last strobe.
    send(1'b1, 3'd4, {16'hCAFF, 16'h123F}, {16'h00AF, 16'h777F},
         {16'hCAF0, 16'h1230}, {16'h00A0, 16'h7770}, 8'hFF, 8'hFF);
    idle(7);
    chk_outs("pre_expiry", {16'hCAF0, 16'h1230}, {16'h00A0, 16'h7770}, 8'hFF, 8'hFF, 1'b0);
    idle(1);
    chk_outs("expiry", {16'hCAF0, 16'h1230}, {16'h00A0, 16'h7770}, 8'h00, 8'h00, 1'b1);
    idle(3);
    chk_outs("stale_hold", {16'hCAF0, 16'h1230}, {16'h00A0, 16'h7770}, 8'h00, 8'h00, 1'b1);
    send(1'b0, 3'd0, {16'h0102, 16'h0304}, {16'h0506, 16'h0708},
         {16'h0102, 16'h0304}, {16'h0506, 16'h0708}, 8'h00, 8'h00);

    // Strobe landing on the would-be expiry edge suppresses the stale pulse.
    idle(7);
    send(1'b1, 3'd3, {16'h000F, 16'h0009}, {16'h0000, 16'h0001},
         {16'h0008, 16'h0008}, {16'h0000, 16'h0000}, 8'h71, 8'h01);
    chk("expiry_race_stale", stale, 1'b0);

    // Full-rate stream with reset mid-stream.
    for (int n = 0; n < 10; n++) begin
      lo = 16'(n);
      hi = 16'(n + 256);
      if (n == 5) begin
        reset = 1'b1; strobe = 1'b1; i_in = {hi, lo}; q_in = ~{hi, lo};
        step();
        chk_outs("midreset", 32'h0, 32'h0, 8'h0, 8'h0, 1'b0);
        chk("midreset_out_strobe", out_strobe, 1'b0);
        reset = 1'b0;
      end else begin
        send(1'b0, 3'd2, {hi, lo}, ~{hi, lo}, {hi, lo}, ~{hi, lo}, 8'h00, 8'h00);
        if (n == 6) chk("post_reset_out_strobe", out_strobe, 1'b1);
      end
    end

    idle(3);
    chk("sb_drain", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
